// File: rtl/nibble_word_packer_if.sv
// Handshake bundle between a nibble source, the packer and a packed-word
// consumer. "master" is the packer's view; "slave" is the environment's view.
//
// Both channels use valid/ready: a transfer happens on a rising clock edge
// where valid and ready are both 1. A producer holds its payload stable while
// valid is 1 and ready is 0, and ready never depends on valid combinationally.
interface nibble_word_packer_if #(
   parameter int NIB_W = 4,
   parameter int NIBS  = 3
);
   localparam int CNT_W = $clog2(NIBS + 1);

   logic                           in_valid;
   logic                           in_ready;
   logic [NIB_W-1:0]               in_nib;
   logic                           in_last;
   logic                           out_valid;
   logic                           out_ready;
   logic [2:NIBS+1][NIB_W:1]       out_word;
   logic [CNT_W-1:0]               out_count;
   logic                           out_all_ones;

   modport master (
      input  in_valid, in_nib, in_last, out_ready,
      output in_ready, out_valid, out_word, out_count, out_all_ones
   );

   modport slave (
      output in_valid, in_nib, in_last, out_ready,
      input  in_ready, out_valid, out_word, out_count, out_all_ones
   );
endinterface

// File: rtl/nibble_word_packer.sv
// Packs a stream of nibbles into 3x4 packed words, padding short words with
// all-ones. One slot assembles while a second slot presents the finished
// word, so input keeps flowing while the consumer stalls for one word.
module nibble_word_packer #(
   parameter int NIB_W = 4,
   parameter int NIBS  = 3
) (
   input  logic                         clk,
   input  logic                         rst_n,
   nibble_word_packer_if.master         io_bus,
   output logic                         o_dbg_state
);
   localparam int CNT_W = $clog2(NIBS + 1);

   typedef enum logic {ST_FILL = 1'b0, ST_HOLD = 1'b1} asm_state_t;

   asm_state_t                   r_state, w_state_nxt;
   logic [2:NIBS+1][NIB_W:1]     r_asm_word, w_asm_word_nxt, w_built;
   logic [CNT_W-1:0]             r_asm_cnt, w_asm_cnt_nxt, w_cnt_inc;
   logic [2:NIBS+1][NIB_W:1]     r_out_word;
   logic [CNT_W-1:0]             r_out_count;
   logic                         r_out_valid;
   logic                         r_out_all_ones;

   logic                         w_accept;
   logic                         w_complete;
   logic                         w_drain;
   logic                         w_out_free;
   logic                         w_load;
   logic [2:NIBS+1][NIB_W:1]     w_load_word;
   logic [CNT_W-1:0]             w_load_cnt;

   // in_ready depends only on the registered assembly state
   assign io_bus.in_ready     = (r_state == ST_FILL);
   assign io_bus.out_valid    = r_out_valid;
   assign io_bus.out_word     = r_out_word;
   assign io_bus.out_count    = r_out_count;
   assign io_bus.out_all_ones = r_out_all_ones;
   assign o_dbg_state         = r_state;

   assign w_accept   = io_bus.in_valid && (r_state == ST_FILL);
   assign w_cnt_inc  = r_asm_cnt + CNT_W'(1);
   assign w_complete = w_accept && ((w_cnt_inc == CNT_W'(NIBS)) || io_bus.in_last);
   assign w_drain    = r_out_valid && io_bus.out_ready;
   assign w_out_free = !r_out_valid || w_drain;

   // Assembly state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_FILL;
         r_asm_word <= '1;
         r_asm_cnt  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_asm_word <= w_asm_word_nxt;
         r_asm_cnt  <= w_asm_cnt_nxt;
      end
   end

   // Next assembly state and the word (if any) handed to the output slot
   always_comb begin
      w_state_nxt    = r_state;
      w_asm_word_nxt = r_asm_word;
      w_asm_cnt_nxt  = r_asm_cnt;
      w_load         = 1'b0;
      w_load_word    = r_asm_word;
      w_load_cnt     = r_asm_cnt;
      w_built        = r_asm_word;
      for (int e = 0; e < NIBS; e++) begin
         if (r_asm_cnt == CNT_W'(e)) w_built[e+2] = io_bus.in_nib;
      end
      case (r_state)
         ST_FILL: begin
            if (w_complete && w_out_free) begin
               // Finished word goes straight out; slot restarts empty
               w_load         = 1'b1;
               w_load_word    = w_built;
               w_load_cnt     = w_cnt_inc;
               w_asm_word_nxt = '1;
               w_asm_cnt_nxt  = '0;
            end else if (w_complete) begin
               // Output busy: park the finished word here
               w_asm_word_nxt = w_built;
               w_asm_cnt_nxt  = w_cnt_inc;
               w_state_nxt    = ST_HOLD;
            end else if (w_accept) begin
               w_asm_word_nxt = w_built;
               w_asm_cnt_nxt  = w_cnt_inc;
            end
         end
         ST_HOLD: begin
            if (w_drain) begin
               w_load         = 1'b1;
               w_asm_word_nxt = '1;
               w_asm_cnt_nxt  = '0;
               w_state_nxt    = ST_FILL;
            end
         end
         default: w_state_nxt = ST_FILL;
      endcase
   end

   // Output slot: load wins over drain so back-to-back words never gap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid    <= 1'b0;
         r_out_word     <= '1;
         r_out_count    <= '0;
         r_out_all_ones <= 1'b1;
      end else if (w_load) begin
         r_out_valid    <= 1'b1;
         r_out_word     <= w_load_word;
         r_out_count    <= w_load_cnt;
         r_out_all_ones <= &w_load_word;
      end else if (w_drain) begin
         r_out_valid    <= 1'b0;
      end
   end
endmodule

// File: tb/tb_nibble_word_packer.sv
// Bench for nibble_word_packer: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a queue model.
module tb_nibble_word_packer;
  localparam int NIB_W = 4;
  localparam int NIBS  = 3;
  localparam int CNT_W = 2;
  localparam int W     = NIBS * NIB_W + CNT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic dbg_state;
  always #5 clk = ~clk;

  nibble_word_packer_if #(.NIB_W(NIB_W), .NIBS(NIBS)) bus ();

  nibble_word_packer #(.NIB_W(NIB_W), .NIBS(NIBS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .io_bus      (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];   // {count, word} of finished, undelivered words
  logic [3:0]   part_q[$];  // nibbles of the word being assembled
  int n_tests = 0;
  int n_fail = 0;
  int n_drained = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: at most two finished words can be outstanding (output + parked),
  // input is refused exactly when two are outstanding.
  always @(negedge clk) begin
    logic [W-1:0] front;
    logic [11:0]  w;
    logic         exp_ready, exp_valid;
    if (!rst_n) begin
      exp_q.delete();
      part_q.delete();
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_word", 32'(bus.out_word), 32'hFFF);
      check("rst_out_count", 32'(bus.out_count), 32'd0);
      check("rst_all_ones", 32'(bus.out_all_ones), 32'd1);
    end else begin
      exp_ready = (exp_q.size() < 2);
      exp_valid = (exp_q.size() > 0);
      check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
      check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
      if (exp_valid) begin
        front = exp_q[0];
        check("out_word", 32'(bus.out_word), 32'(front[11:0]));
        check("out_count", 32'(bus.out_count), 32'(front[W-1:12]));
        check("out_all_ones", 32'(bus.out_all_ones), 32'(&front[11:0]));
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          n_drained++;
        end
      end
      if (bus.in_valid && exp_ready) begin
        part_q.push_back(bus.in_nib);
        if (bus.in_last || part_q.size() == NIBS) begin
          w = 12'hFFF;
          for (int i = 0; i < part_q.size(); i++) w[11-4*i -: 4] = part_q[i];
          exp_q.push_back({CNT_W'(part_q.size()), w});
          part_q.delete();
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one nibble and hold it until taken; returns at posedge+1 after accept
  task automatic send(input logic [3:0] nib, input logic last);
    bus.in_valid = 1'b1;
    bus.in_nib   = nib;
    bus.in_last  = last;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        return;
      end
      step();
    end
    n_tests++;
    n_fail++;
    $display("FAIL send_timeout: nibble %0h not accepted within 50 cycles", nib);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int drained_before;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_nib    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    step();
    rst_n = 1'b1;

    // Full word, drained immediately
    bus.out_ready = 1'b1;
    send(4'hA, 1'b0); send(4'h5, 1'b0); send(4'h3, 1'b0);
    @(negedge clk);
    check("t1_valid", 32'(bus.out_valid), 32'd1);
    check("t1_word", 32'(bus.out_word), 32'hA53);
    check("t1_count", 32'(bus.out_count), 32'd3);
    check("t1_all_ones", 32'(bus.out_all_ones), 32'd0);
    step();

    // Single nibble closed early
    send(4'h7, 1'b1);
    @(negedge clk);
    check("t2_word", 32'(bus.out_word), 32'h7FF);
    check("t2_count", 32'(bus.out_count), 32'd1);
    check("t2_all_ones", 32'(bus.out_all_ones), 32'd0);
    step();

    // Padding counts as ones
    send(4'hF, 1'b0); send(4'hF, 1'b1);
    @(negedge clk);
    check("t3_word", 32'(bus.out_word), 32'hFFF);
    check("t3_count", 32'(bus.out_count), 32'd2);
    check("t3_all_ones", 32'(bus.out_all_ones), 32'd1);
    step();
    step();

    // Stall: one word presented, one parked
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) send(4'(i), 1'b0);
    @(negedge clk);
    check("t4_hold_ready", 32'(bus.in_ready), 32'd0);
    check("t4_hold_word", 32'(bus.out_word), 32'h123);
    check("t4_hold_valid", 32'(bus.out_valid), 32'd1);
    step();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("t4_next_word", 32'(bus.out_word), 32'h456);
    check("t4_next_valid", 32'(bus.out_valid), 32'd1);
    check("t4_next_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.out_ready = 1'b1;
    step();
    step();

    // Back-to-back words
    drained_before = n_drained;
    for (int i = 0; i < 30; i++) send(4'($urandom_range(0, 15)), 1'b0);
    step();
    step();
    check("t5_words", 32'(n_drained - drained_before), 32'd10);

    // Asynchronous reset with a pending word and a partial word
    bus.out_ready = 1'b0;
    send(4'h8, 1'b0); send(4'h9, 1'b0); send(4'hE, 1'b0);
    send(4'h1, 1'b0); send(4'h2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    check("t6_rst_ready", 32'(bus.in_ready), 32'd1);
    check("t6_rst_word", 32'(bus.out_word), 32'hFFF);
    repeat (2) @(negedge clk);
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send(4'hB, 1'b0); send(4'hC, 1'b0); send(4'hD, 1'b0);
    @(negedge clk);
    check("t6_word", 32'(bus.out_word), 32'hBCD);
    check("t6_count", 32'(bus.out_count), 32'd3);
    step();

    // Randomized traffic with random early closes and back-pressure
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_nib    = 4'($urandom_range(0, 15));
      bus.in_last   = ($urandom_range(0, 3) == 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) step();
    @(negedge clk);
    check("final_empty", 32'(bus.out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
